// File: rtl/eth_pkg.sv
// Shared types and constants for the RMII receive path.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } rx_state_t;

    localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0] SFD_DIBIT      = 2'b11;
    localparam int         ETH_MIN_BYTES  = 64;
    localparam int         ETH_MAX_BYTES  = 1522;

endpackage

// File: rtl/ether_rx.sv
// RMII receive framer: strips preamble/SFD, streams payload dibits and
// reports frame length and error at end of frame.
module ether_rx
    import eth_pkg::*;
#(
    parameter int MIN_PREAMBLE = 8,
    parameter int MIN_DIBITS   = ETH_MIN_BYTES * 4,
    parameter int MAX_DIBITS   = ETH_MAX_BYTES * 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        crsdv,
    input  logic [1:0]  rxd,
    output logic        axiov,
    output logic [1:0]  axiod,
    output logic        axiof,
    output logic        axioe,
    output logic [15:0] frame_len
);

    localparam logic [7:0]  MIN_PRE = 8'(MIN_PREAMBLE);
    localparam logic [12:0] MIN_D   = 13'(MIN_DIBITS);
    localparam logic [12:0] MAX_D   = 13'(MAX_DIBITS);

    rx_state_t   state_q, state_d;
    logic [7:0]  pre_cnt_q, pre_cnt_d;
    logic [12:0] dcnt_q, dcnt_d;
    logic        axiov_q, axiov_d;
    logic [1:0]  axiod_q, axiod_d;
    logic        axiof_q, axiof_d;
    logic        axioe_q, axioe_d;
    logic [15:0] frame_len_q, frame_len_d;

    logic sfd_ok;
    logic at_max;

    assign sfd_ok = (rxd == SFD_DIBIT) && (pre_cnt_q >= MIN_PRE);
    assign at_max = (dcnt_q == MAX_D);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            pre_cnt_q   <= '0;
            dcnt_q      <= '0;
            axiov_q     <= 1'b0;
            axiod_q     <= 2'b00;
            axiof_q     <= 1'b0;
            axioe_q     <= 1'b0;
            frame_len_q <= '0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            dcnt_q      <= dcnt_d;
            axiov_q     <= axiov_d;
            axiod_q     <= axiod_d;
            axiof_q     <= axiof_d;
            axioe_q     <= axioe_d;
            frame_len_q <= frame_len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (crsdv && rxd == PREAMBLE_DIBIT) state_d = PREAMBLE;
                else if (crsdv && rxd[1])           state_d = DROP;
            end
            PREAMBLE: begin
                if (!crsdv)                      state_d = IDLE;
                else if (rxd == PREAMBLE_DIBIT)  state_d = PREAMBLE;
                else if (sfd_ok)                 state_d = DATA;
                else                             state_d = DROP;
            end
            DATA: begin
                if (!crsdv)      state_d = IDLE;
                else if (at_max) state_d = DROP;
            end
            DROP: begin
                if (!crsdv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters and registered outputs; the SFD dibit and any dibit past
    // the oversize limit are never forwarded.
    always_comb begin
        pre_cnt_d   = pre_cnt_q;
        dcnt_d      = dcnt_q;
        axiov_d     = 1'b0;
        axiod_d     = 2'b00;
        axiof_d     = 1'b0;
        axioe_d     = 1'b0;
        frame_len_d = frame_len_q;
        case (state_q)
            IDLE: begin
                if (crsdv && rxd == PREAMBLE_DIBIT) pre_cnt_d = 8'd1;
            end
            PREAMBLE: begin
                if (crsdv && rxd == PREAMBLE_DIBIT && pre_cnt_q != 8'hFF)
                    pre_cnt_d = pre_cnt_q + 8'd1;
                if (crsdv && sfd_ok)
                    dcnt_d = '0;
            end
            DATA: begin
                if (!crsdv) begin
                    axiof_d     = 1'b1;
                    axioe_d     = (dcnt_q[1:0] != 2'b00) || (dcnt_q < MIN_D);
                    frame_len_d = {5'b0, dcnt_q[12:2]};
                end else if (at_max) begin
                    axiof_d     = 1'b1;
                    axioe_d     = 1'b1;
                    frame_len_d = {5'b0, MAX_D[12:2]};
                end else begin
                    axiov_d = 1'b1;
                    axiod_d = rxd;
                    dcnt_d  = dcnt_q + 13'd1;
                end
            end
            default: ;
        endcase
    end

    assign axiov     = axiov_q;
    assign axiod     = axiod_q;
    assign axiof     = axiof_q;
    assign axioe     = axioe_q;
    assign frame_len = frame_len_q;

endmodule
